btn_sw_conditioner: RTL

- Input-conditioning stage directly upstream of the calculator top level.
- Takes the five raw board push-buttons and 16 raw slide switches and synchronises them to clk.
- Debounces each button independently and emits a clean level plus a single-cycle press pulse.
- The press pulse lets the accumulator clear or load exactly once per physical press, not on every clock while the button is held.

---
 rtl/btn_sw_conditioner.sv | 92 +++++++++
 1 files changed

// File: rtl/btn_sw_conditioner.sv
// Input conditioning for the calculator: 2-FF synchronisers on buttons and switches,
// per-button debounce with a clean level and a one-cycle press pulse.
module btn_sw_conditioner #(
  parameter int N_BTN     = 5,
  parameter int N_SW      = 16,
  parameter int DB_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_SW-1:0]  sw_sync
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic {STABLE, PENDING} db_state_t;

  logic [N_BTN-1:0] btn_s1_p1, btn_s2_p2;
  logic [N_SW-1:0]  sw_s1_p1, sw_s2_p2;

  db_state_t        state_q [N_BTN];
  db_state_t        state_d [N_BTN];
  logic [CNT_W-1:0] cnt_q   [N_BTN];
  logic [CNT_W-1:0] cnt_d   [N_BTN];
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] pulse_q, pulse_d;

  // Stage p1/p2: two-flop synchroniser for every raw input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_p1 <= '0;
      btn_s2_p2 <= '0;
      sw_s1_p1  <= '0;
      sw_s2_p2  <= '0;
    end else begin
      btn_s1_p1 <= btn_raw;
      btn_s2_p2 <= btn_s1_p1;
      sw_s1_p1  <= sw_raw;
      sw_s2_p2  <= sw_s1_p1;
    end
  end

  // Debounce: any cycle where s2 agrees with the level restarts the count
  always_comb begin
    level_d = level_q;
    pulse_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (btn_s2_p2[i] == level_q[i]) begin
        state_d[i] = STABLE;
        cnt_d[i]   = '0;
      end else if (((state_q[i] == PENDING) ? cnt_q[i] : '0) == CNT_LAST) begin
        level_d[i] = btn_s2_p2[i];
        pulse_d[i] = btn_s2_p2[i];
        state_d[i] = STABLE;
        cnt_d[i]   = '0;
      end else begin
        state_d[i] = PENDING;
        cnt_d[i]   = ((state_q[i] == PENDING) ? cnt_q[i] : '0) + CNT_W'(1);
      end
    end
  end

  // Stage p3: debounce state, level and pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
      level_q <= '0;
      pulse_q <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;
  assign sw_sync   = sw_s2_p2;

endmodule
